// File: rtl/quasi_static_hub_pkg.sv
// Shared state encoding and default timing constants for the quasi-static IRQ hub.
package quasi_static_hub_pkg;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StDone
  } hub_state_e;

  localparam int unsigned DefaultStableCycles = 4;
  localparam int unsigned DefaultDrainCycles  = 8;

endpackage

// File: rtl/quasi_static_stabilizer.sv
// Holds an accepted value that only follows its input once the input has been
// sampled unchanged on STABLE_CYCLES consecutive rising edges.
module quasi_static_stabilizer
  import quasi_static_hub_pkg::*;
#(
  parameter int unsigned WIDTH         = 1,
  parameter int unsigned STABLE_CYCLES = DefaultStableCycles
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] value,
  output logic             update
);

  localparam int unsigned    CntW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);

  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] value_q, value_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             update_q, update_d;

  always_comb begin
    count_d  = count_q;
    value_d  = value_q;
    update_d = 1'b0;
    if (sample != last_q) begin
      count_d = CntW'(1);
    end else if (count_q != CntMax) begin
      count_d = count_q + CntW'(1);
    end
    // The count saturates, so a settled input keeps re-accepting the same value.
    if (count_d == CntMax) begin
      value_d  = sample;
      update_d = (sample != value_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q   <= '0;
      count_q  <= '0;
      value_q  <= '0;
      update_q <= 1'b0;
    end else begin
      last_q   <= sample;
      count_q  <= count_d;
      value_q  <= value_d;
      update_q <= update_d;
    end
  end

  assign value  = value_q;
  assign update = update_q;

endmodule

// File: rtl/quasi_static_irq_hub.sv
// Stabilizes per-CPU IRQ words and finish flags, routes IRQs transposed, and
// sequences end-of-simulation. Optional update counter: QS_IRQ_HUB_STATS_EN.
module quasi_static_irq_hub
  import quasi_static_hub_pkg::*;
#(
  parameter int unsigned NUM_CPUS      = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned STABLE_CYCLES = DefaultStableCycles,
  parameter int unsigned DRAIN_CYCLES  = DefaultDrainCycles
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CPUS-1:0][DATA_WIDTH-1:0] irq_in,
  input  logic [NUM_CPUS-1:0]                 finish_in,
  output logic [NUM_CPUS-1:0][DATA_WIDTH-1:0] irq_out,
  output logic [NUM_CPUS-1:0]                 finished,
  output logic                                done,
  output logic [31:0]                         update_count
);

  localparam int unsigned    DrW       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DrW-1:0] DrainLast = DrW'(DRAIN_CYCLES - 1);

  logic [NUM_CPUS-1:0][DATA_WIDTH-1:0] irq_val;
  logic [NUM_CPUS-1:0][DATA_WIDTH-1:0] irq_route;
  logic [NUM_CPUS-1:0][DATA_WIDTH-1:0] irq_out_q;
  logic [NUM_CPUS-1:0]                 irq_upd;
  logic [NUM_CPUS-1:0]                 fin_val;
  logic [NUM_CPUS-1:0]                 fin_upd;
  logic [NUM_CPUS-1:0]                 finished_q, finished_d;

  hub_state_e     state_q, state_d;
  logic [DrW-1:0] drain_q, drain_d;

  for (genvar i = 0; i < NUM_CPUS; i++) begin : g_cpu
    quasi_static_stabilizer #(
      .WIDTH        (DATA_WIDTH),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_irq_stab (
      .clk   (clk),
      .rst   (rst),
      .sample(irq_in[i]),
      .value (irq_val[i]),
      .update(irq_upd[i])
    );

    quasi_static_stabilizer #(
      .WIDTH        (1),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_fin_stab (
      .clk   (clk),
      .rst   (rst),
      .sample(finish_in[i]),
      .value (fin_val[i]),
      .update(fin_upd[i])
    );
  end

  // Word j of the output collects bit j of every CPU's accepted word.
  always_comb begin
    irq_route = '0;
    for (int j = 0; j < NUM_CPUS; j++) begin
      for (int i = 0; i < NUM_CPUS; i++) begin
        irq_route[j][i] = irq_val[i][j];
      end
    end
  end

  // Accepted values only move together with their update pulse, so loading on
  // any pulse is equivalent to loading every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_out_q <= '0;
    end else if (|irq_upd) begin
      irq_out_q <= irq_route;
    end
  end

  assign finished_d = finished_q | (fin_val & fin_upd);

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      StRun: begin
        if (&finished_d) begin
          state_d = StDrain;
          drain_d = '0;
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + DrW'(1);
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      finished_q <= '0;
      state_q    <= StRun;
      drain_q    <= '0;
    end else begin
      finished_q <= finished_d;
      state_q    <= state_d;
      drain_q    <= drain_d;
    end
  end

  assign irq_out  = irq_out_q;
  assign finished = finished_q;
  assign done     = (state_q == StDone);

`ifdef QS_IRQ_HUB_STATS_EN
  logic [31:0] count_q;
  logic [32:0] count_sum;
  logic [5:0]  n_upd;

  // Counts with the same one-edge lag as irq_out so both move together.
  always_comb begin
    n_upd = '0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      n_upd = n_upd + 6'(irq_upd[i]);
    end
    count_sum = {1'b0, count_q} + 33'(n_upd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_sum[32] ? 32'hFFFF_FFFF : count_sum[31:0];
    end
  end

  assign update_count = count_q;
`else
  assign update_count = '0;
`endif

endmodule

// File: tb/tb_quasi_static_irq_hub.sv
// Randomized and directed bench for quasi_static_irq_hub with an event scoreboard
// fed by a history-based reference model.
module tb_quasi_static_irq_hub;

  localparam int N = 4;
  localparam int W = 32;
  localparam int S = 4;
  localparam int D = 8;

`ifdef QS_IRQ_HUB_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  typedef logic [W-1:0] word_t;

  typedef struct packed {
    logic [N-1:0][W-1:0] irq;
    logic [N-1:0]        fin;
    logic                dn;
    logic [31:0]         cnt;
  } snap_t;

  typedef struct {
    int    e;
    snap_t s;
  } ev_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N-1:0][W-1:0] irq_in;
  logic [N-1:0]        finish_in;
  logic [N-1:0][W-1:0] irq_out;
  logic [N-1:0]        finished;
  logic                done;
  logic [31:0]         update_count;

  int  n_cmp  = 0;
  int  n_fail = 0;
  int  edge_no = 0;
  bit  mon_en = 1'b0;
  ev_t evq[$];

  quasi_static_irq_hub #(
    .NUM_CPUS     (N),
    .DATA_WIDTH   (W),
    .STABLE_CYCLES(S),
    .DRAIN_CYCLES (D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_in      (irq_in),
    .finish_in   (finish_in),
    .irq_out     (irq_out),
    .finished    (finished),
    .done        (done),
    .update_count(update_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", name, act, req, edge_no);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: a value is accepted once the last S samples all agree;
  // outputs reflect the accepted state one edge later.
  word_t hist [2*N][$];
  word_t acc  [2*N];
  initial begin
    snap_t        exp_s, exp_prev;
    logic [N-1:0] fin_sticky;
    int           drain_start, pending;
    longint       cnt_m;
    word_t        smp;
    bit           eq;
    exp_prev = '0; exp_s = '0; fin_sticky = '0;
    drain_start = -1; pending = 0; cnt_m = 0;
    for (int c = 0; c < 2*N; c++) acc[c] = '0;
    forever begin
      @(posedge clk);
      edge_no++;
      if (rst) begin
        for (int c = 0; c < 2*N; c++) begin
          hist[c].delete();
          acc[c] = '0;
        end
        fin_sticky = '0; drain_start = -1; pending = 0; cnt_m = 0;
        exp_s = '0;
      end else begin
        exp_s.irq = '0;
        for (int j = 0; j < N; j++)
          for (int i = 0; i < N; i++) exp_s.irq[j][i] = acc[i][j];
        for (int i = 0; i < N; i++) if (acc[N+i][0]) fin_sticky[i] = 1'b1;
        if (StatsEn) begin
          cnt_m = cnt_m + pending;
          if (cnt_m > 64'hFFFF_FFFF) cnt_m = 64'hFFFF_FFFF;
        end
        if (drain_start < 0 && &fin_sticky) drain_start = edge_no;
        exp_s.fin = fin_sticky;
        exp_s.dn  = (drain_start >= 0) && (edge_no - drain_start >= D);
        exp_s.cnt = cnt_m[31:0];
        pending = 0;
        for (int c = 0; c < 2*N; c++) begin
          smp = (c < N) ? irq_in[c] : W'(finish_in[c-N]);
          hist[c].push_back(smp);
          if (hist[c].size() > S) void'(hist[c].pop_front());
          eq = (hist[c].size() == S);
          for (int k = 0; k < hist[c].size(); k++) if (hist[c][k] != smp) eq = 1'b0;
          if (eq) begin
            if (c < N && smp != acc[c]) pending++;
            acc[c] = smp;
          end
        end
      end
      if (exp_s !== exp_prev) evq.push_back('{e: edge_no, s: exp_s});
      exp_prev = exp_s;
    end
  end

  // Monitor: every observed or expected output change is matched against the queue.
  initial begin
    snap_t cur, last_dut;
    ev_t   ev;
    bit    exp_here, dut_chg;
    last_dut = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur = '{irq: irq_out, fin: finished, dn: done, cnt: update_count};
        while (evq.size() > 0 && evq[0].e < edge_no) begin
          ev = evq.pop_front();
          n_cmp++; n_fail++;
          $display("FAIL missed_event: expected change at edge %0d to 0x%0h never matched",
                   ev.e, ev.s);
        end
        exp_here = (evq.size() > 0) && (evq[0].e == edge_no);
        dut_chg  = (cur !== last_dut);
        if (exp_here || dut_chg) begin
          n_cmp++;
          if (!exp_here) begin
            n_fail++;
            $display("FAIL unexpected_change: edge %0d got 0x%0h, want 0x%0h",
                     edge_no, cur, last_dut);
          end else begin
            ev = evq.pop_front();
            if (cur !== ev.s) begin
              n_fail++;
              $display("FAIL output_event: edge %0d got 0x%0h, want 0x%0h", edge_no, cur, ev.s);
            end
          end
        end
        last_dut = cur;
      end
    end
  end

  function automatic word_t pick(input word_t prev);
    case ($urandom_range(4))
      0:       return '0;
      1:       return word_t'(1) << $urandom_range(N - 1);
      2:       return word_t'($urandom);
      3:       return prev ^ (word_t'(1) << $urandom_range(W - 1));
      default: return word_t'(32'h0000_000F);
    endcase
  endfunction

  task automatic random_irq(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(5) == 0) irq_in[i] = pick(irq_in[i]);
      step(1);
    end
  endtask

  initial begin
    int found;
    irq_in = '0;
    finish_in = '0;
    rst = 1'b1;
    step(3);
    for (int j = 0; j < N; j++) check($sformatf("reset_irq_out%0d", j), 64'(irq_out[j]), 64'd0);
    check("reset_finished", 64'(finished), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_update_count", 64'(update_count), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Single word held: appears transposed exactly S edges after first sample.
    irq_in[1] = 32'h0000_0004;
    step(S);
    check("single_early", 64'(irq_out[2]), 64'd0);
    step(1);
    check("single_out2", 64'(irq_out[2]), 64'h2);
    check("single_out0", 64'(irq_out[0]), 64'd0);
    check("single_out1", 64'(irq_out[1]), 64'd0);
    check("single_out3", 64'(irq_out[3]), 64'd0);
    check("single_count", 64'(update_count), StatsEn ? 64'd1 : 64'd0);

    // Toggling faster than the stability window must never be accepted.
    for (int k = 0; k < 10; k++) begin
      irq_in[0] = (k % 2 == 0) ? 32'h1 : 32'h0;
      step(2);
    end
    irq_in[0] = '0;
    step(6);
    check("toggle_out0", 64'(irq_out[0]), 64'd0);
    check("toggle_count", 64'(update_count), StatsEn ? 64'd1 : 64'd0);

    // Two CPUs changing on the same edge.
    irq_in[0] = 32'h3;
    irq_in[3] = 32'h1;
    step(S);
    check("dual_early", 64'(irq_out[0]), 64'd0);
    step(1);
    check("dual_out0", 64'(irq_out[0]), 64'h9);
    check("dual_out1", 64'(irq_out[1]), 64'h1);
    check("dual_count", 64'(update_count), StatsEn ? 64'd3 : 64'd0);

    random_irq(400);
    step(8);

    // Staggered finishes, CPU 2 drops after acceptance; routing keeps running.
    finish_in[0] = 1'b1; step(3);
    finish_in[1] = 1'b1; step(7);
    finish_in[3] = 1'b1; step(2);
    finish_in[2] = 1'b1; step(6);
    finish_in[2] = 1'b0;
    random_irq(25);
    step(6);
    check("finish_sticky", 64'(finished), 64'hF);
    check("finish_done", 64'(done), 64'd1);

    // Reset in the middle of draining, then measure the full restart latency.
    finish_in = '1;
    rst = 1'b1; step(2);
    rst = 1'b0; step(8);
    rst = 1'b1; step(1);
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_finished", 64'(finished), 64'd0);
    check("midreset_out0", 64'(irq_out[0]), 64'd0);
    check("midreset_count", 64'(update_count), 64'd0);
    rst = 1'b0;
    found = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (done === 1'b1 && found == 0) found = k;
    end
    check("restart_done_latency", 64'(found), 64'(S + 1 + D));

    step(10);
    check("scoreboard_drained", 64'(evq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
